avalon_st_sink: RTL and testbench

AVALON_ST_SINK -- requirements
Module: avalon_st_sink

---
 rtl/avalon_st_sink.sv | 122 ++++++++++++
 tb/tb_avalon_st_sink.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/avalon_st_sink.sv
// Avalon-ST sink: 4-deep beat FIFO feeding a 3-beat packet assembler with ack handshake.
// Optional beat-sequence checking is enabled by defining AVALON_SINK_SEQ_CHECK_EN.
module avalon_st_sink (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  output logic        ready,
  input  logic [7:0]  data,
  output logic [23:0] word_out,
  output logic        word_valid,
  input  logic        word_ack,
  output logic [7:0]  pkt_count,
  output logic        seq_err
);

  // state | meaning
  // COL0  | waiting to pop beat0 (word_out[23:16])
  // COL1  | waiting to pop beat1 (word_out[15:8])
  // COL2  | waiting to pop beat2 (word_out[7:0]); pop completes the packet
  // HOLD  | word_out presented with word_valid=1 until word_ack
  typedef enum logic [1:0] {COL0 = 2'd0, COL1 = 2'd1, COL2 = 2'd2, HOLD = 2'd3} state_t;

  state_t      state;
  logic [7:0]  mem [4];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic [2:0]  count;
  logic [7:0]  beat0;
  logic [7:0]  beat1;
  logic [7:0]  head;
  logic        push;
  logic        pop;

  // ready depends only on the registered count, so a same-cycle pop cannot unblock a full FIFO
  assign ready = (count != 3'd4) && !reset;
  assign push  = valid && ready;
  assign pop   = (state != HOLD) && (count != 3'd0);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= 2'd0;
      rd_ptr     <= 2'd0;
      count      <= 3'd0;
      state      <= COL0;
      beat0      <= 8'd0;
      beat1      <= 8'd0;
      word_out   <= 24'd0;
      word_valid <= 1'b0;
      pkt_count  <= 8'd0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase

      case (state)
        COL0: begin
          if (pop) begin
            beat0 <= head;
            state <= COL1;
          end
        end
        COL1: begin
          if (pop) begin
            beat1 <= head;
            state <= COL2;
          end
        end
        COL2: begin
          if (pop) begin
            word_out   <= {beat0, beat1, head};
            word_valid <= 1'b1;
            pkt_count  <= pkt_count + 8'd1;
            state      <= HOLD;
          end
        end
        HOLD: begin
          if (word_ack) begin
            word_valid <= 1'b0;
            state      <= COL0;
          end
        end
        default: state <= COL0;
      endcase
    end
  end

`ifdef AVALON_SINK_SEQ_CHECK_EN
  // Beat n of every packet is expected to carry 4+n; mismatches latch until reset.
  localparam logic [7:0] SEQ_BASE = 8'd4;
  logic [7:0] seq_expected;
  logic       seq_err_q;

  assign seq_expected = SEQ_BASE + {6'd0, state};
  assign seq_err      = seq_err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      seq_err_q <= 1'b0;
    end else if (pop && (head != seq_expected)) begin
      seq_err_q <= 1'b1;
    end
  end
`else
  assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_avalon_st_sink.sv
// Directed self-checking bench for avalon_st_sink; expectations follow the macro build.
module tb_avalon_st_sink;

  logic        clk;
  logic        reset;
  logic        valid;
  logic        ready;
  logic [7:0]  data;
  logic [23:0] word_out;
  logic        word_valid;
  logic        word_ack;
  logic [7:0]  pkt_count;
  logic        seq_err;

  int n_assert = 0;
  int n_fail   = 0;
  int acc;
  logic exp_seq;

  avalon_st_sink dut (
    .clk        (clk),
    .reset      (reset),
    .valid      (valid),
    .ready      (ready),
    .data       (data),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ack   (word_ack),
    .pkt_count  (pkt_count),
    .seq_err    (seq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called and returns at a falling edge.
  task automatic do_reset();
    reset    = 1'b1;
    valid    = 1'b0;
    data     = 'x;
    word_ack = 1'b0;
    @(negedge clk);
    check("ready_in_reset", {31'd0, ready}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Offers one beat until accepted, then returns at the next falling edge with valid still set.
  task automatic send_beat(input logic [7:0] b);
    int t;
    t = 0;
    valid = 1'b1;
    data  = b;
    while (!ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("send_ready", {31'd0, ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_word(input string tag, input logic [23:0] exp);
    int t;
    t = 0;
    while (!word_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_valid"}, {31'd0, word_valid}, 32'd1);
    check({tag, "_word"}, {8'd0, word_out}, {8'd0, exp});
  endtask

  initial begin
`ifdef AVALON_SINK_SEQ_CHECK_EN
    exp_seq = 1'b1;
`else
    exp_seq = 1'b0;
`endif
    reset    = 1'b1;
    valid    = 1'b0;
    data     = 8'h00;
    word_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_word_valid", {31'd0, word_valid}, 32'd0);
    check("rst_word_out", {8'd0, word_out}, 32'd0);
    check("rst_pkt_count", {24'd0, pkt_count}, 32'd0);
    check("rst_seq_err", {31'd0, seq_err}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_rst", {31'd0, ready}, 32'd1);

    // Basic packet, ack held high beforehand (ack without word_valid must be harmless).
    word_ack = 1'b1;
    valid = 1'b1; data = 8'h04; @(negedge clk);
    data = 8'h05; @(negedge clk);
    data = 8'h06; @(negedge clk);
    valid = 1'b0; data = 'x;
    check("basic_not_yet", {31'd0, word_valid}, 32'd0);
    @(negedge clk);
    check("basic_valid", {31'd0, word_valid}, 32'd1);
    check("basic_word", {8'd0, word_out}, 32'h040506);
    check("basic_pkt", {24'd0, pkt_count}, 32'd1);
    @(negedge clk);
    check("basic_valid_drop", {31'd0, word_valid}, 32'd0);
    check("basic_word_stable", {8'd0, word_out}, 32'h040506);

    // Backpressure: ack low, beats offered continuously for 10 cycles.
    do_reset();
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      valid = 1'b1;
      data  = 8'h10 + 8'(acc);
      if (ready) acc++;
      @(negedge clk);
    end
    check("bp_accepted", acc, 32'd7);
    check("bp_ready_low", {31'd0, ready}, 32'd0);
    check("bp_valid", {31'd0, word_valid}, 32'd1);
    check("bp_word", {8'd0, word_out}, 32'h101112);
    check("bp_pkt", {24'd0, pkt_count}, 32'd1);
    word_ack = 1'b1;
    @(negedge clk);
    word_ack = 1'b0;
    check("bp_ack_drop", {31'd0, word_valid}, 32'd0);
    check("bp_still_full", {31'd0, ready}, 32'd0);
    @(negedge clk);
    check("bp_ready_back", {31'd0, ready}, 32'd1);
    valid = 1'b0; data = 'x;
    wait_word("bp_next", 24'h131415);
    check("bp_pkt2", {24'd0, pkt_count}, 32'd2);

    // Sequence check: 4,7,6 then a good packet.
    do_reset();
    send_beat(8'h04);
    send_beat(8'h07);
    check("seq_before_bad_pop", {31'd0, seq_err}, 32'd0);
    send_beat(8'h06);
    valid = 1'b0; data = 'x;
    check("seq_after_bad_pop", {31'd0, seq_err}, {31'd0, exp_seq});
    wait_word("seq_bad", 24'h040706);
    word_ack = 1'b1;
    @(negedge clk);
    word_ack = 1'b0;
    send_beat(8'h04);
    send_beat(8'h05);
    send_beat(8'h06);
    valid = 1'b0; data = 'x;
    wait_word("seq_good", 24'h040506);
    check("seq_sticky", {31'd0, seq_err}, {31'd0, exp_seq});
    check("seq_pkt", {24'd0, pkt_count}, 32'd2);

    // Reset mid-packet discards partial and buffered beats.
    do_reset();
    send_beat(8'h04);
    send_beat(8'h05);
    do_reset();
    check("mid_rst_valid", {31'd0, word_valid}, 32'd0);
    check("mid_rst_pkt", {24'd0, pkt_count}, 32'd0);
    send_beat(8'h04);
    send_beat(8'h05);
    send_beat(8'h06);
    valid = 1'b0; data = 'x;
    wait_word("mid_rst", 24'h040506);
    check("mid_rst_pkt1", {24'd0, pkt_count}, 32'd1);

    // Packet counter wrap.
    do_reset();
    word_ack = 1'b1;
    for (int p = 0; p < 256; p++) begin
      send_beat(8'h04);
      send_beat(8'h05);
      send_beat(8'h06);
      valid = 1'b0; data = 'x;
      wait_word("wrap_loop", 24'h040506);
      @(negedge clk);
    end
    check("wrap_256", {24'd0, pkt_count}, 32'd0);
    send_beat(8'h04);
    send_beat(8'h05);
    send_beat(8'h06);
    valid = 1'b0; data = 'x;
    wait_word("wrap_257", 24'h040506);
    check("wrap_257_count", {24'd0, pkt_count}, 32'd1);
    check("wrap_seq_err", {31'd0, seq_err}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
